// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad by driving one column low at a time and reading
// the pulled-up rows. A key that is seen at the end of a column dwell has to
// stay stable for DEBOUNCE cycles before it is accepted. Then it has to be
// fully released for DEBOUNCE cycles before scanning resumes. Accepted keys
// are shifted into a four-digit entry register.
//
// Parameters
//   DWELL     cycles each column is driven before its rows are judged (>= 3,
//             so the 2-flop row synchronizer has caught up with the column)
//   DEBOUNCE  consecutive stable cycles needed for a press and for a release
//
// Ports
//   refresh_clock  single clock, all state changes on its rising edge
//   reset_n        asynchronous active-low reset
//   row_in[3:0]    keypad rows, active-low, asynchronous to refresh_clock
//   col_out[3:0]   column drive, active-low one-hot
//   key_valid      one-cycle pulse per accepted key press
//   key_code[3:0]  {row_idx, col_idx} of the last accepted key
//   entry[15:0]    last four accepted codes, newest in [3:0]
//   entry_done     one-cycle pulse together with every 4th key_valid
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic        refresh_clock,
  input  logic        reset_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic        entry_done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE - 1);

  // The state register is left as a plain named signal so checkers can bind
  // to it directly.
  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [SW-1:0] stable;
  logic [3:0]    pattern;
  logic [1:0]    digit;
  logic [3:0]    new_code;

  // Lowest-numbered low row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] p);
    if (!p[0])      return 2'd0;
    else if (!p[1]) return 2'd1;
    else if (!p[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign col_out  = ~(4'b0001 << col);
  assign new_code = {low_row(pattern), col};

  // Rows are asynchronous; two flops before anything looks at them. The
  // reset value is "no key", matching the pull-ups.
  always_ff @(posedge refresh_clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  always_ff @(posedge refresh_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_SCAN;
      col        <= 2'd0;
      dwell      <= '0;
      stable     <= '0;
      pattern    <= 4'hF;
      digit      <= 2'd0;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
      entry      <= 16'h0000;
      entry_done <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      entry_done <= 1'b0;
      case (state)
        S_SCAN: begin
          if (dwell == DWELL_LAST) begin
            if (row_s == 4'hF) begin
              col   <= col + 2'd1;
              dwell <= '0;
            end else begin
              // Column stays frozen from here until the key is released.
              pattern <= row_s;
              stable  <= '0;
              state   <= S_DEBOUNCE;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (row_s == pattern) begin
            stable <= stable + 1'b1;
            if (stable == STABLE_LAST) begin
              key_valid  <= 1'b1;
              key_code   <= new_code;
              entry      <= {entry[11:0], new_code};
              entry_done <= (digit == 2'd3);
              digit      <= digit + 2'd1;
              state      <= S_HELD;
            end
          end else begin
            // Bounce: rescan the same column from the start of its dwell.
            dwell <= '0;
            state <= S_SCAN;
          end
        end
        S_HELD: begin
          if (row_s == 4'hF) begin
            stable <= '0;
            state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (row_s != 4'hF) begin
            state <= S_HELD;
          end else if (stable == STABLE_LAST) begin
            col   <= col + 2'd1;
            dwell <= '0;
            state <= S_SCAN;
          end else begin
            stable <= stable + 1'b1;
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 4: cycles each column is driven before its rows are evaluated (min 3).
REQ-002 SHALL have parameter DEBOUNCE, default 8: consecutive stable cycles required for press and for release (min 1).
REQ-003 SHALL have port refresh_clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port row_in, input, 4: keypad rows, active-low, pulled up, asynchronous to refresh_clock.
REQ-006 SHALL have port col_out, output, 4: column drive, active-low one-hot.
REQ-007 SHALL have port key_valid, output, 1: one-cycle pulse per accepted key press.
REQ-008 SHALL have port key_code, output, 4: code of the last accepted key.
REQ-009 SHALL have port entry, output, 16: last four accepted codes, newest in [3:0].
REQ-010 SHALL have port entry_done, output, 1: one-cycle pulse on every 4th accepted key.

Function
REQ-011 SHALL pass row_in through a 2-flop synchronizer; all logic below uses the synchronized value row_s.
REQ-012 SHALL hold a 2-bit column index col; col_out = ~(4'b0001 << col).
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 SCAN: dwell counter counts 0..DWELL-1 per column; at count DWELL-1, if row_s == 4'hF, SHALL advance col (3 wraps to 0) and clear dwell.
REQ-015 SCAN: at count DWELL-1 with row_s != 4'hF, SHALL latch col and row_s pattern, clear the stable counter, go DEBOUNCE; col frozen.
REQ-016 DEBOUNCE: each cycle row_s equals latched pattern SHALL increment the stable counter; any mismatch SHALL return to SCAN with dwell cleared and col unchanged, no output.
REQ-017 DEBOUNCE: when the stable counter reaches DEBOUNCE, SHALL in the same edge pulse key_valid, load key_code, shift entry and go HELD.
REQ-018 key_code SHALL be {row_idx, col_idx}, row_idx = index of the lowest-numbered low bit of the latched pattern (multi-row press: lowest row wins).
REQ-019 entry update SHALL be entry <= {entry[11:0], key_code_new}; a 2-bit digit counter increments per accepted key, wrapping 3->0.
REQ-020 entry_done SHALL pulse in the same cycle as key_valid when the digit counter is 3 before increment.
REQ-021 HELD: while row_s != 4'hF SHALL remain, no further key_valid (no auto-repeat); on row_s == 4'hF SHALL clear the stable counter and go RELEASE.
REQ-022 RELEASE: SHALL count consecutive row_s == 4'hF cycles; any low row returns to HELD; reaching DEBOUNCE SHALL go SCAN with col advanced by one and dwell cleared.
REQ-023 key_code and entry SHALL hold their values between accepted keys.
REQ-024 Latency: a stable press seen by row_s at dwell end produces key_valid exactly DEBOUNCE cycles later.

Reset
REQ-025 reset_n low SHALL asynchronously force: state SCAN, col 0, col_out 4'b1110, dwell 0, stable counter 0, synchronizer flops 4'hF, key_valid 0, key_code 0, entry 16'h0000, digit counter 0, entry_done 0.
REQ-026 Reset asserted mid-DEBOUNCE or HELD SHALL discard the pending key with no pulse; after release, operation starts at col 0.

Verification
REQ-027 Idle: rows 4'hF, defaults -> col_out cycles 1110,1101,1011,0111,1110 each held 4 cycles; no key_valid.
REQ-028 Single key: row 2 low while col 1 driven, held 20 cycles -> one key_valid, key_code 4'h9, entry 16'h0009; col_out frozen at 1101 until release.
REQ-029 Bounce: row pulse 3 cycles low then high -> no key_valid, scanning resumes at same column.
REQ-030 Four keys codes 1,2,3,4 with full releases -> entry 16'h1234, entry_done pulses once with 4th key_valid; 5th key 5 -> entry 16'h2345, no entry_done.
REQ-031 Multi-row: rows 0 and 3 low on col 2 -> key_code 4'h2.
REQ-032 Reset mid-HELD: assert reset_n low -> all outputs to reset values immediately, no key_valid on release.
